cla_serial_adder: RTL and testbench
===================================

Name: cla_serial_adder

Overview:
- Multi-cycle wide adder/subtractor built around one `cla_4bit` slice.
- Latches two WIDTH-bit operands on a start handshake.
- Feeds the slice one 4-bit nibble per cycle, LSB first, and chains the nibble carry through a carry register.
- Publishes the registered WIDTH-bit result with a one-cycle done pulse, so wide datapaths reuse the existing 4-bit CLA.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of 4 and at least 8.
- NIB (derived, localparam), WIDTH/4, number of nibble cycles per operation.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while busy=0.
- sub  input  1  0: a+b+cin; 1: a-b (cin ignored); latched with the operands.
- a  input  WIDTH  operand A; latched when start is accepted.
- b  input  WIDTH  operand B; latched when start is accepted.
- cin  input  1  carry-in for add mode; latched when start is accepted.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; result valid from this cycle on.
- sum  output  WIDTH  registered result; holds until the next completion.
- cout  output  1  registered final carry; in sub mode 1 = no borrow (a >= b unsigned).

Behaviour:
- Reset (rst=1 at an edge), regardless of state:
  - FSM goes to IDLE; busy=0, done=0, sum=0, cout=0.
  - Nibble counter, operand registers, partial-sum accumulator and carry register all cleared.
  - An in-flight operation is discarded and never produces done.
- FSM states are IDLE and RUN.
- IDLE:
  - start=1 at edge E0 latches a, sub?~b:b, and carry = sub?1:cin; clears counter k=0; moves to RUN.
  - busy=1 from the cycle after E0.
- RUN, cycle k (0..NIB-1):
  - Slice inputs are A[4k+3:4k], B'[4k+3:4k] and the carry register.
  - At the next edge: slice sum is written into accumulator bits [4k+3:4k]; slice cout goes into the carry register; k increments.
- Completion, at the edge ending RUN cycle k=NIB-1 (edge E_NIB):
  - sum <= full accumulator including the last nibble; cout <= last slice carry.
  - done <= 1 for exactly one cycle; busy <= 0; FSM returns to IDLE.
- Latency: done is high in the cycle NIB clocks after the accepting edge (WIDTH=16: the 4th cycle after E0). Throughput is one operation per NIB cycles.
- sum/cout never show partial results; they change only at completion or reset.
- start while busy=1 is ignored entirely (no queueing, no restart). Operand changes during RUN have no effect.
- start=1 in the done cycle (busy=0) is accepted; back-to-back operations with no idle gap are legal.
- Arithmetic is unsigned modulo 2^WIDTH. There is no overflow flag; signed overflow is the consumer's job.
- No combinational path from any input to any output.

Decomposition:
- Shared package `cla_pkg`:
  - NIB_W = 4 constant.
  - FSM state typedef {IDLE, RUN}.
  - Function computing NIB from WIDTH, plus an elaboration-time check that WIDTH % 4 == 0.
- Sub-module: exactly one `cla_4bit` instance used as the nibble slice. No other sub-modules; counter, muxing and FSM live in this block.

Test Plan (WIDTH=16):
- Add:
  - Stimulus: a=0x1234, b=0x4321, sub=0, cin=0, start pulse.
  - Response: done 4 cycles after the accepting edge, sum=0x5555, cout=0; busy high for exactly 4 cycles.
- Carry chain:
  - Stimulus: a=0xFFFF, b=0x0001, cin=0.
  - Response: sum=0x0000, cout=1.
  - Repeat with a=0xFFFF, b=0x0000, cin=1: sum=0x0000, cout=1.
- Subtract:
  - Stimulus: sub=1, a=0x0005, b=0x0007, cin=1.
  - Response: sum=0xFFFE, cout=0 (cin ignored).
  - Then a=0x0007, b=0x0005: sum=0x0002, cout=1.
- Ignored start:
  - Stimulus: start a=0x0001, b=0x0001; two cycles later start again with a=0x00FF, b=0x0001.
  - Response: single done, sum=0x0002, no second done.
- Reset mid-op:
  - Stimulus: start a=0x1111, b=0x2222; assert rst in RUN cycle 2.
  - Response: next cycle busy=0, sum=0, cout=0; done never asserted for that operation.
- Back-to-back:
  - Stimulus: start asserted in the done cycle of a previous op, with a=0x8000, b=0x8000.
  - Response: accepted; next done 4 cycles later with sum=0x0000, cout=1; previous result held until then.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared definitions for the nibble-serial CLA adder: slice width, FSM
// state encoding and width helpers used at elaboration time.
package cla_pkg;

  localparam int NIB_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int calc_nib(input int width);
    return width / NIB_W;
  endfunction

  // Width must split evenly into nibbles and give at least two of them.
  function automatic bit width_ok(input int width);
    return ((width % NIB_W) == 0) && (width >= 2 * NIB_W);
  endfunction

endpackage

// File: rtl/cla_4bit.sv
// Four-bit carry-lookahead adder slice; purely combinational.
module cla_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Every carry is expanded directly from c_i so no ripple path exists.
  assign c[0] = c_i;
  assign c[1] = g[0] | (p[0] & c_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c_i);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c_i);

  assign s_o = p ^ c[3:0];
  assign c_o = c[4];

endmodule

// File: rtl/cla_serial_adder.sv
// Wide add/subtract that walks the operands one nibble per cycle through a
// single cla_4bit slice, chaining the carry through a register.
module cla_serial_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIB = calc_nib(WIDTH);
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

  generate
    if (!width_ok(WIDTH)) begin : g_width_check
      $error("cla_serial_adder: WIDTH must be a multiple of 4 and >= 8");
    end
  endgenerate

  // Handshake: start is sampled only while busy=0; an accepted request
  // produces exactly one done pulse NIB cycles later unless rst intervenes.

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;

  logic [NIB_W-1:0] nib_a;
  logic [NIB_W-1:0] nib_b;
  logic [NIB_W-1:0] nib_s;
  logic             nib_c;
  logic             last_nib;

  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int n = 0; n < NIB; n++) begin
      if (k_q == KW'(n)) begin
        nib_a = a_q[n*NIB_W +: NIB_W];
        nib_b = b_q[n*NIB_W +: NIB_W];
      end
    end
  end

  assign last_nib = (k_q == KW'(NIB - 1));

  cla_4bit u_slice (
    .a_i (nib_a),
    .b_i (nib_b),
    .c_i (carry_q),
    .s_o (nib_s),
    .c_o (nib_c)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction is a + ~b + 1, so B is inverted and carry forced.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          k_d     = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        for (int n = 0; n < NIB; n++) begin
          if (k_q == KW'(n)) begin
            acc_d[n*NIB_W +: NIB_W] = nib_s;
          end
        end
        carry_d = nib_c;
        k_d     = k_q + 1'b1;
        if (last_nib) begin
          sum_d   = acc_d;
          cout_d  = nib_c;
          done_d  = 1'b1;
          k_d     = '0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_cla_serial_adder.sv
// Directed scoreboard bench for cla_serial_adder at WIDTH=16.
module tb_cla_serial_adder;

  localparam int WIDTH = 16;
  localparam int NIB   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  cla_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  // ---------------- clock / reset bookkeeping ----------------
  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_edge = 1'b1;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= rst;
  end

  // ---------------- scoreboard ----------------
  logic [WIDTH:0] exp_q[$];
  int             lat_q[$];
  int             n_vec = 0;
  int             n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  int             busy_run  = 0;
  logic [WIDTH-1:0] last_sum  = '0;
  logic           last_cout = 1'b0;
  logic [WIDTH:0] e;
  int             l;

  always @(negedge clk) begin
    if (rst_edge) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: got done=1 sum=%h, expected no done (cycle %0d)", sum, cyc);
        end else begin
          e = exp_q.pop_front();
          l = lat_q.pop_front();
          check("sum", 32'(sum), 32'(e[WIDTH-1:0]));
          check("cout", 32'(cout), 32'(e[WIDTH]));
          check("done_latency", cyc, l);
          check("busy_cycles", busy_run, NIB);
        end
        busy_run = 0;
      end else begin
        check("hold_sum", 32'(sum), 32'(last_sum));
        check("hold_cout", 32'(cout), 32'(last_cout));
      end
    end
    last_sum  = sum;
    last_cout = cout;
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                       input logic ts, input logic tc, input bit push,
                       input logic [WIDTH-1:0] es, input logic ec);
    a     = ta;
    b     = tb_;
    sub   = ts;
    cin   = tc;
    start = 1'b1;
    if (push) begin
      exp_q.push_back({ec, es});
      lat_q.push_back(cyc + 1 + NIB);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got no done within %0d cycles, expected done", t);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_timeout: got busy=1 after %0d cycles, expected busy=0", t);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum",  32'(sum),  32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // plain add, carry chain, add with cin
    issue(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, 16'h5555, 1'b0); wait_done(); @(negedge clk);
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1); wait_done(); @(negedge clk);
    issue(16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1); wait_done(); @(negedge clk);
    issue(16'h0F0F, 16'h00F1, 1'b0, 1'b1, 1'b1, 16'h1001, 1'b0); wait_done(); @(negedge clk);

    // subtract: borrow and no-borrow, cin ignored
    issue(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1, 16'hFFFE, 1'b0); wait_done(); @(negedge clk);
    issue(16'h0007, 16'h0005, 1'b1, 1'b0, 1'b1, 16'h0002, 1'b1); wait_done(); @(negedge clk);

    // start while busy must be ignored
    issue(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0);
    @(negedge clk);
    a = 16'h00FF; b = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (8) @(negedge clk);

    // reset in RUN cycle 2 discards the operation
    issue(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sum",  32'(sum),  32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // back-to-back: second start lands in the done cycle of the first
    issue(16'h00F0, 16'h0F0F, 1'b0, 1'b0, 1'b1, 16'h0FFF, 1'b0);
    wait_done();
    check("b2b_idle_in_done", 32'(busy), 32'd0);
    issue(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1);
    wait_done();
    @(negedge clk);
    wait_idle();
    repeat (6) @(negedge clk);

    check("pending_expected", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test by %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
